// File: rtl/grover_controller.sv
// rtl/grover_controller.sv - Grover search sequencer: load, iterate through external operator, scan for max |amp|.
// Optional result_prob output (squared amplitude) enabled by macro GROVER_PROB_EN.
module grover_controller #(
   parameter int NUM_BIT        = 3,
   parameter int FIXEDPOINT_BIT = 24,
   parameter int NUM_SAMPLE     = 2**NUM_BIT,
   parameter logic [FIXEDPOINT_BIT-1:0] INIT_AMP = 24'h16A09E
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [NUM_BIT-1:0]                     target_search,
   input  logic [7:0]                             num_iter,
   output logic [NUM_BIT-1:0]                     op_target,
   output logic [NUM_SAMPLE*FIXEDPOINT_BIT-1:0]   state_to_op,
   input  logic [NUM_SAMPLE*FIXEDPOINT_BIT-1:0]   state_from_op,
   output logic                                   busy,
   output logic                                   done,
   output logic [NUM_BIT-1:0]                     result_index,
   output logic signed [FIXEDPOINT_BIT-1:0]       result_amp
`ifdef GROVER_PROB_EN
   ,
   output logic [FIXEDPOINT_BIT-1:0]              result_prob
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_SCAN = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int VW = NUM_SAMPLE * FIXEDPOINT_BIT;

   state_t                             state_q, state_d;
   logic [NUM_BIT-1:0]                 target_q, target_d;
   logic [7:0]                         iter_q, iter_d;
   logic [7:0]                         cnt_q, cnt_d;
   logic [VW-1:0]                      vec_q, vec_d;
   logic [NUM_BIT-1:0]                 scan_idx_q, scan_idx_d;
   logic [FIXEDPOINT_BIT:0]            max_mag_q, max_mag_d;
   logic [NUM_BIT-1:0]                 max_idx_q, max_idx_d;
   logic signed [FIXEDPOINT_BIT-1:0]   max_amp_q, max_amp_d;
   logic [NUM_BIT-1:0]                 res_idx_q, res_idx_d;
   logic signed [FIXEDPOINT_BIT-1:0]   res_amp_q, res_amp_d;

   logic signed [FIXEDPOINT_BIT-1:0]   cur_amp;
   logic signed [FIXEDPOINT_BIT:0]     cur_ext;
   logic [FIXEDPOINT_BIT:0]            cur_mag;
   logic                               take;
   logic [FIXEDPOINT_BIT:0]            best_mag;
   logic [NUM_BIT-1:0]                 best_idx;
   logic signed [FIXEDPOINT_BIT-1:0]   best_amp;
   logic                               scan_last;

   // Magnitude carries one extra bit so that |most negative| is representable.
   always_comb begin
      cur_amp   = vec_q[int'(scan_idx_q)*FIXEDPOINT_BIT +: FIXEDPOINT_BIT];
      cur_ext   = {cur_amp[FIXEDPOINT_BIT-1], cur_amp};
      cur_mag   = cur_ext[FIXEDPOINT_BIT] ? unsigned'(-cur_ext) : unsigned'(cur_ext);
      take      = (scan_idx_q == '0) || (cur_mag > max_mag_q);
      best_mag  = take ? cur_mag : max_mag_q;
      best_idx  = take ? scan_idx_q : max_idx_q;
      best_amp  = take ? cur_amp : max_amp_q;
      scan_last = (scan_idx_q == NUM_BIT'(NUM_SAMPLE - 1));
   end

`ifdef GROVER_PROB_EN
   logic signed [2*FIXEDPOINT_BIT-1:0] amp_sq;
   logic [FIXEDPOINT_BIT-1:0]          prob_q, prob_d;

   always_comb begin
      amp_sq = best_amp * best_amp;
   end
`endif

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      iter_d     = iter_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      scan_idx_d = scan_idx_q;
      max_mag_d  = max_mag_q;
      max_idx_d  = max_idx_q;
      max_amp_d  = max_amp_q;
      res_idx_d  = res_idx_q;
      res_amp_d  = res_amp_q;
`ifdef GROVER_PROB_EN
      prob_d     = prob_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = target_search;
               iter_d   = num_iter;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            vec_d      = {NUM_SAMPLE{INIT_AMP}};
            cnt_d      = iter_q;
            scan_idx_d = '0;
            state_d    = (iter_q != 8'd0) ? S_ITER : S_SCAN;
         end
         S_ITER: begin
            vec_d = state_from_op;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            max_mag_d  = best_mag;
            max_idx_d  = best_idx;
            max_amp_d  = best_amp;
            scan_idx_d = scan_idx_q + NUM_BIT'(1);
            // Results are captured here so they are already valid while done is high.
            if (scan_last) begin
               res_idx_d = best_idx;
               res_amp_d = best_amp;
`ifdef GROVER_PROB_EN
               prob_d    = amp_sq[FIXEDPOINT_BIT-2 +: FIXEDPOINT_BIT];
`endif
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         target_q   <= '0;
         iter_q     <= '0;
         cnt_q      <= '0;
         vec_q      <= '0;
         scan_idx_q <= '0;
         max_mag_q  <= '0;
         max_idx_q  <= '0;
         max_amp_q  <= '0;
         res_idx_q  <= '0;
         res_amp_q  <= '0;
`ifdef GROVER_PROB_EN
         prob_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         iter_q     <= iter_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         scan_idx_q <= scan_idx_d;
         max_mag_q  <= max_mag_d;
         max_idx_q  <= max_idx_d;
         max_amp_q  <= max_amp_d;
         res_idx_q  <= res_idx_d;
         res_amp_q  <= res_amp_d;
`ifdef GROVER_PROB_EN
         prob_q     <= prob_d;
`endif
      end
   end

   assign op_target    = target_q;
   assign state_to_op  = vec_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign result_index = res_idx_q;
   assign result_amp   = res_amp_q;
`ifdef GROVER_PROB_EN
   assign result_prob  = prob_q;
`endif

endmodule

// File: doc/grover_controller.md
GROVER_CONTROLLER -- requirements
Module: grover_controller

Interface
REQ-001 SHALL have parameter NUM_BIT, default 3, qubit count / search index width.
REQ-002 SHALL have parameter FIXEDPOINT_BIT, default 24, amplitude width (Q1.22: sign, 1 integer bit, 22 fraction bits).
REQ-003 SHALL have parameter NUM_SAMPLE, default 2**NUM_BIT, state vector length.
REQ-004 SHALL have parameter INIT_AMP, default 24'h16A09E, uniform amplitude 1/sqrt(NUM_SAMPLE) in Q1.22.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-008 SHALL have port target_search  input  NUM_BIT  oracle target index; latched on accepted start.
REQ-009 SHALL have port num_iter  input  8  Grover iteration count; latched on accepted start.
REQ-010 SHALL have port op_target  output  NUM_BIT  latched target driven to the downstream grover_operator.
REQ-011 SHALL have port state_to_op  output  signed FIXEDPOINT_BIT x NUM_SAMPLE  registered state vector driven to the operator input.
REQ-012 SHALL have port state_from_op  input  signed FIXEDPOINT_BIT x NUM_SAMPLE  combinational operator result (one Grover iteration applied).
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-015 SHALL have port result_index  output  NUM_BIT  measured index (max |amplitude|).
REQ-016 SHALL have port result_amp  output  signed FIXEDPOINT_BIT  signed amplitude at result_index.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, ITER, SCAN, DONE.
REQ-018 SHALL move IDLE->LOAD on start=1, latching target_search and num_iter; start outside IDLE SHALL be ignored.
REQ-019 SHALL, in LOAD (1 cycle), write INIT_AMP into all NUM_SAMPLE state registers and load iteration counter with num_iter.
REQ-020 SHALL go LOAD->ITER if counter!=0, else LOAD->SCAN.
REQ-021 SHALL, each ITER cycle, register state_from_op into the state vector and decrement the counter; leave ITER for SCAN on the cycle the counter goes 1->0.
REQ-022 SHALL, in SCAN, examine one entry per cycle, index 0 to NUM_SAMPLE-1, keeping the running max of |amp|; a strictly greater magnitude SHALL replace the max (ties keep lowest index).
REQ-023 SHALL compute |amp| at FIXEDPOINT_BIT+1 bits so the most negative value does not overflow.
REQ-024 SHALL go SCAN->DONE after entry NUM_SAMPLE-1 is examined; DONE lasts 1 cycle, asserts done, updates result_index/result_amp, then returns to IDLE.
REQ-025 SHALL have total latency from accepted start to done of 1+num_iter+NUM_SAMPLE+1 cycles.
REQ-026 SHALL hold result_index, result_amp and state vector stable from DONE until the next LOAD.
REQ-027 SHALL drive op_target from the latched target at all times, never directly from target_search.

Reset
REQ-028 SHALL, on rst=1 at a clock edge in any state (including mid-ITER or mid-SCAN), enter IDLE and clear counter, state vector, op_target, result_index, result_amp, busy and done to 0.
REQ-029 SHALL give rst priority over start in the same cycle.

Configuration
REQ-030 SHALL, with macro GROVER_PROB_EN defined, add output result_prob (unsigned FIXEDPOINT_BIT, Q1.22 value of result_amp squared, truncated), registered in DONE and reset to 0.
REQ-031 SHALL, without GROVER_PROB_EN, omit the result_prob port and the multiplier; all other behaviour is identical.

Verification
REQ-032 SHALL cover: N=8, target=5, num_iter=2 -> done at cycle 12 after start; result_index=5, result_amp ~ 0.9723 (4078000 +/-16 LSB); other entries ~ -0.0884.
REQ-033 SHALL cover: target=3, num_iter=1 -> result_index=3, result_amp ~ 0.8839 (3707000 +/-16 LSB), others ~ 0.1768; done 11 cycles after start.
REQ-034 SHALL cover: num_iter=0 -> no ITER cycles; all amps 24'h16A09E, result_index=0 (tie rule); done 10 cycles after start.
REQ-035 SHALL cover: rst asserted during ITER, then start with target=7, num_iter=2 -> outputs 0 after reset; second run gives result_index=7 and no residue from the aborted run.
REQ-036 SHALL cover: start pulsed while busy with a different target -> ignored; result matches the first request; busy low only after DONE.
REQ-037 SHALL cover: with GROVER_PROB_EN, target=5, num_iter=2 -> result_prob ~ 0.9453 (3965000 +/-32 LSB).
